// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and slot state for the demux1x4_buf fan-out.
// Optional drain counters are enabled with DEMUX1X4_STATS_EN.
package demux_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 2;
    localparam int NPORT  = 4;
    localparam int STAT_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_st_t;

    function automatic logic [NPORT-1:0] sel_dec(
        input logic [SEL_W-1:0] s
    );
        logic [NPORT-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer with valid/ready drain.
// DEMUX1X4_STATS_EN adds a wrapping drain counter with sync clear.
module demux_slot
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
`ifdef DEMUX1X4_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [STAT_W-1:0] cnt_o
`endif
);

    slot_st_t          state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              drain;

    assign drain   = (state_q == SLOT_FULL) && ready_i;
    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load while FULL only happens together with a drain (in_ready).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load_i) state_d = SLOT_EMPTY;
        endcase
        if (load_i) data_d = data_i;
    end

`ifdef DEMUX1X4_STATS_EN
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr_i)
            cnt_d = '0;
        else if (drain)
            cnt_d = cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux1x4_buf.sv
// demux1x4_buf: routes one stream to four buffered sinks by in_sel.
// Define DEMUX1X4_STATS_EN for per-port drain counters (stat_cnt/stat_clr).
module demux1x4_buf
    import demux_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NPORT-1:0]        out_valid,
    input  logic [NPORT-1:0]        out_ready,
    output logic [NPORT*DATA_W-1:0] out_data
`ifdef DEMUX1X4_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [NPORT*STAT_W-1:0] stat_cnt
`endif
);

    logic             accept;
    logic [NPORT-1:0] load;

    // Only the addressed slot gates the producer.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;
    assign load     = accept ? sel_dec(in_sel) : '0;

    for (genvar k = 0; k < NPORT; k++) begin : g_slot
        demux_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load[k]),
            .data_i     (in_data),
            .ready_i    (out_ready[k]),
            .valid_o    (out_valid[k]),
            .data_o     (out_data[k*DATA_W +: DATA_W])
`ifdef DEMUX1X4_STATS_EN
            ,
            .stat_clr_i (stat_clr),
            .cnt_o      (stat_cnt[k*STAT_W +: STAT_W])
`endif
        );
    end

endmodule

// File: tb/tb_demux1x4_buf.sv
// tb_demux1x4_buf: vector table plus per-port scoreboard for demux1x4_buf.
// Covers stats counters too when built with DEMUX1X4_STATS_EN.
module tb_demux1x4_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [31:0]  in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_data;
`ifdef DEMUX1X4_STATS_EN
    logic         stat_clr;
    logic [63:0]  stat_cnt;
`endif

    int npass = 0;
    int ntot  = 0;

    logic [31:0] sbq [4][$];

    always #5 clk = ~clk;

    demux1x4_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX1X4_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    function automatic void chk(input string nm,
                                input logic [127:0] act,
                                input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic logic [31:0] pdata(input int k);
        return out_data[k*32 +: 32];
    endfunction

    // Scoreboard: outputs sampled mid-cycle, so a visible drain/accept
    // here is what the next rising edge will commit.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        ntot++;
                        $display("FAIL sb_port%0d: got %h expected none",
                                 k, pdata(k));
                    end else begin
                        chk($sformatf("sb_port%0d", k),
                            128'(pdata(k)), 128'(sbq[k].pop_front()));
                    end
                end
            end
            if (in_valid && in_ready)
                sbq[in_sel].push_back(in_data);
        end
    end

    task automatic cyc(input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic        exp_rdy;
        logic [3:0]  exp_vld;
        logic        chk_d;
        logic [1:0]  dport;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[1] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[3] = '{1'b1, 2'd1, 32'h11,       4'b1101, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[4] = '{1'b1, 2'd1, 32'h22,       4'b1101, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h11};
        tbl[5] = '{1'b1, 2'd3, 32'h33,       4'b1101, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h0};
        tbl[6] = '{1'b1, 2'd1, 32'h22,       4'b1101, 1'b0, 4'b1010, 1'b1, 2'd3, 32'h33};
        tbl[7] = '{1'b1, 2'd1, 32'h22,       4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};
        tbl[8] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h22};
        tbl[9] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'h0;
        out_ready = 4'b1111;
`ifdef DEMUX1X4_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 2'd0, 32'h0, 4'b1111);
            chk("idle_valid", 128'(out_valid), 128'(4'b0000));
            chk("idle_ready", 128'(in_ready), 128'(1'b1));
            chk("idle_data", out_data, 128'h0);
        end

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy);
            chk($sformatf("vec%0d_ready", i),
                128'(in_ready), 128'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d_valid", i),
                128'(out_valid), 128'(tbl[i].exp_vld));
            if (tbl[i].chk_d)
                chk($sformatf("vec%0d_data", i),
                    128'(pdata(int'(tbl[i].dport))), 128'(tbl[i].exp_d));
        end

        for (int i = 0; i < 10; i++) begin
            cyc(i < 8, 2'd0, 32'(i + 1), 4'b1111);
            chk($sformatf("stream%0d_ready", i), 128'(in_ready), 128'(1'b1));
            chk($sformatf("stream%0d_valid", i),
                128'(out_valid[0]), 128'(i >= 1 && i <= 8));
            if (i >= 1 && i <= 8)
                chk($sformatf("stream%0d_data", i),
                    128'(pdata(0)), 128'(i));
        end

        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 2'(k), 32'hA0 + 32'(k), 4'b0000);
            chk($sformatf("fill%0d_ready", k), 128'(in_ready), 128'(1'b1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("prerst_valid", 128'(out_valid), 128'(4'b1111));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        chk("rst_valid", 128'(out_valid), 128'(4'b0000));
        chk("rst_data", out_data, 128'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'd0, 32'h0, 4'b1111);
            chk("postrst_valid", 128'(out_valid), 128'(4'b0000));
        end

`ifdef DEMUX1X4_STATS_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("stat_rst", 128'(stat_cnt), 128'h0);
        for (int i = 0; i < 65537; i++)
            cyc(1'b1, 2'd0, 32'(i), 4'b1111);
        cyc(1'b0, 2'd0, 32'h0, 4'b1111);
        cyc(1'b0, 2'd0, 32'h0, 4'b1111);
        chk("stat_wrap0", 128'(stat_cnt[15:0]), 128'(16'd1));
        chk("stat_others", 128'(stat_cnt[63:16]), 128'h0);
        cyc(1'b1, 2'd0, 32'h5A, 4'b1111);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk);
        chk("stat_clr_drain_vld", 128'(out_valid[0]), 128'(1'b1));
        @(posedge clk);
        #1 stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr0", 128'(stat_cnt[15:0]), 128'(16'd0));
`endif

        for (int k = 0; k < 4; k++)
            chk($sformatf("sb_left%0d", k), 128'(sbq[k].size()), 128'(0));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
